// File: rtl/alu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one shift-add or restoring-divide step per cycle.
// Operands are latched as magnitudes at accept; the sign fix-up is applied on the final step.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      cnt;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   mag_b_r;
  logic [WIDTH-1:0]   raw_a;
  logic               neg_res;
  logic               neg_rem;
  // Upper WIDTH+1 bits: partial product (mul) or running remainder (div).
  // Lower WIDTH bits: multiplier being consumed (mul) or quotient being built (div).
  logic [2*WIDTH:0]   p;
  logic [2*WIDTH:0]   p_step;

  logic               accept;
  logic               last;
  logic               finish;
  logic               is_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  assign busy   = (state == RUN);
  assign valid  = (state == DONE);
  assign accept = start && !cancel && (state != RUN);
  assign last   = (cnt == CW'(WIDTH - 1));
  assign finish = (state == RUN) && last && !cancel;

  assign is_signed = ~op[0];
  assign a_neg     = is_signed & a[WIDTH-1];
  assign b_neg     = is_signed & b[WIDTH-1];
  assign mag_a     = a_neg ? -a : a;
  assign mag_b     = b_neg ? -b : b;

  always_comb begin
    mul_sum  = p[0] ? (p[2*WIDTH:WIDTH] + {1'b0, mag_b_r}) : p[2*WIDTH:WIDTH];
    rem_sh   = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, mag_b_r};
    if (!op_r[1]) begin
      p_step = {1'b0, mul_sum, p[WIDTH-1:1]};
    end else if (rem_sh >= {1'b0, mag_b_r}) begin
      p_step = {rem_diff, p[WIDTH-2:0], 1'b1};
    end else begin
      p_step = {rem_sh, p[WIDTH-2:0], 1'b0};
    end
    prod = neg_res ? -p_step[2*WIDTH-1:0] : p_step[2*WIDTH-1:0];
    quo  = neg_res ? -p_step[WIDTH-1:0] : p_step[WIDTH-1:0];
    rem  = neg_rem ? -p_step[2*WIDTH-1:WIDTH] : p_step[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = accept ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
    if (cancel) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      op_r        <= '0;
      mag_b_r     <= '0;
      raw_a       <= '0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      p           <= '0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_r    <= op;
        mag_b_r <= mag_b;
        raw_a   <= a;
        neg_res <= a_neg ^ b_neg;
        neg_rem <= a_neg;
        p       <= {{(WIDTH+1){1'b0}}, mag_a};
        cnt     <= '0;
      end else if (state == RUN) begin
        p   <= p_step;
        cnt <= cnt + CW'(1);
      end
      if (finish) begin
        if (!op_r[1]) begin
          hi          <= prod[2*WIDTH-1:WIDTH];
          lo          <= prod[WIDTH-1:0];
          div_by_zero <= 1'b0;
        end else if (mag_b_r == '0) begin
          hi          <= raw_a;
          lo          <= '1;
          div_by_zero <= 1'b1;
        end else begin
          hi          <= rem;
          lo          <= quo;
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: directed vector table, randomized ops against an arithmetic model,
// and hand sequences for back-to-back starts, ignored starts, cancel and mid-op reset.
module tb_alu_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cancel;
  logic         busy;
  logic         valid;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
    .busy(busy), .valid(valid), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected {div_by_zero, hi, lo} computed with plain 64-bit arithmetic.
  function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    longint     sx, sy, q, r;
    logic [63:0] u;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: begin
        q = sx * sy;
        u = q;
        return {1'b0, u};
      end
      2'd1: begin
        u = {32'd0, x} * {32'd0, y};
        return {1'b0, u};
      end
      2'd2: begin
        if (y == 0) return {1'b1, x, 32'hFFFFFFFF};
        q = sx / sy;
        r = sx % sy;
        u = {r[31:0], q[31:0]};
        return {1'b0, u};
      end
      default: begin
        if (y == 0) return {1'b1, x, 32'hFFFFFFFF};
        u = {x % y, x / y};
        return {1'b0, u};
      end
    endcase
  endfunction

  // Starts an op at the current cycle (IDLE or DONE), scrambles the operands after the
  // accept edge, optionally pokes start mid-run, and checks the exact completion cycle.
  task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input logic edz, input bit poke);
    int bad;
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0;
    op = 2'($urandom);
    a = $urandom;
    b = $urandom;
    bad = 0;
    for (int i = 0; i < W; i++) begin
      if (!busy || valid) bad++;
      start = poke && (i == 5);
      tick();
    end
    start = 1'b0;
    check({name, " timing"}, 64'(bad), 64'd0);
    check({name, " valid/busy"}, {62'd0, valid, busy}, 64'd2);
    check({name, " hi"}, 64'(hi), 64'(ehi));
    check({name, " lo"}, 64'(lo), 64'(elo));
    check({name, " div_by_zero"}, 64'(div_by_zero), 64'(edz));
  endtask

  initial begin
    logic [2*W:0] e;
    logic [1:0]   ro;
    logic [W-1:0] ra, rb, old_hi, old_lo;
    logic         old_dz;
    int           nv;

    vecs[0] = '{2'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[1] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2] = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3] = '{2'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0};
    vecs[4] = '{2'd3, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};
    vecs[5] = '{2'd1, 32'd3,        32'd4,        32'h00000000, 32'h0000000C, 1'b0};
    vecs[6] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[7] = '{2'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[8] = '{2'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[9] = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};

    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'd0; a = '0; b = '0;
    #2;
    check("reset outputs", {busy, valid, div_by_zero, hi[28:0], lo}, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Consecutive entries are launched in the DONE cycle of the previous op.
    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].dz, 1'b0);
    tick();
    check("valid pulse ends", {62'd0, valid, busy}, 64'd0);
    check("result holds", {hi, lo}, {vecs[9].hi, vecs[9].lo});

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      case ($urandom_range(7))
        0: rb = '0;
        1: rb = 32'($urandom_range(15));
        2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        default: rb = $urandom;
      endcase
      e = model(ro, ra, rb);
      run_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, e[63:32], e[31:0], e[64], 1'b0);
      if ($urandom_range(1) == 1) tick();
    end

    tick();
    run_op("start while busy", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);
    tick();

    old_hi = hi; old_lo = lo; old_dz = div_by_zero;
    start = 1'b1; op = 2'd0; a = 32'd5; b = 32'd7;
    tick();
    start = 1'b0;
    repeat (9) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel busy", 64'(busy), 64'd0);
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid || busy) nv++;
      tick();
    end
    check("cancel no valid", 64'(nv), 64'd0);
    check("cancel keeps hi/lo", {hi, lo}, {old_hi, old_lo});
    check("cancel keeps dz", 64'(div_by_zero), 64'(old_dz));

    start = 1'b1; cancel = 1'b1; op = 2'd1; a = 32'd9; b = 32'd9;
    tick();
    start = 1'b0; cancel = 1'b0;
    check("start+cancel", {62'd0, valid, busy}, 64'd0);

    run_op("dz set", 2'd3, 32'h55, 32'h0, 32'h55, 32'hFFFFFFFF, 1'b1, 1'b0);
    tick();
    start = 1'b1; op = 2'd1; a = 32'hFFFFFFFF; b = 32'h3;
    tick();
    start = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    #1;
    check("reset mid-op", {busy, valid, div_by_zero, hi[28:0], lo}, 64'd0);
    check("reset mid-op hi", 64'(hi), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    run_op("after reset", 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
